// File: rtl/debounce_button_multi.sv
// Multi-channel front-panel key debouncer: per-channel sync, tick-based debounce,
// short/long press classification and an active-low stretched output after short presses.
module debounce_button_multi #(
  parameter int CH      = 4,
  parameter int DEB_MS  = 20,
  parameter int OUT_MS  = 30,
  parameter int LONG_MS = 4000,
  parameter int CW      = 13
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            int_1ms_en,
  input  logic [CH-1:0]   chan_en,
  input  logic [CH-1:0]   key,
  output logic [CH-1:0]   key_level,
  output logic [CH-1:0]   press_pulse,
  output logic [CH-1:0]   release_pulse,
  output logic [CH-1:0]   long_pulse,
  output logic [CH-1:0]   key_out,
  output logic [2*CH-1:0] fsm_state_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] LONG    = 2'd2;
  localparam logic [1:0] STRETCH = 2'd3;

  localparam int DW = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_MS - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
  localparam logic [CW-1:0] OUT_LAST  = CW'(OUT_MS - 1);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic          sync1_q, ks_q;
    logic          lvl_q, lvl_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [1:0]    st_q, st_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic          press_ev, rel_ev, lng_d, kout_d;
    logic          prs_q, rel_q, lng_q, kout_q;

    always_comb begin
      lvl_d  = lvl_q;
      dcnt_d = dcnt_q;
      st_d   = st_q;
      hcnt_d = hcnt_q;
      lng_d  = 1'b0;

      if (ks_q == lvl_q) begin
        dcnt_d = '0;
      end else if (int_1ms_en) begin
        if (dcnt_q == DEB_LAST) begin
          lvl_d  = ks_q;
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      // Edge events line up with the registered pulses, so the FSM sees them in the same clock.
      press_ev = chan_en[c] & lvl_q & ~lvl_d;
      rel_ev   = chan_en[c] & ~lvl_q & lvl_d;

      case (st_q)
        IDLE: begin
          if (press_ev) begin
            st_d   = PRESSED;
            hcnt_d = '0;
          end
        end
        PRESSED: begin
          if (rel_ev) begin
            st_d   = STRETCH;
            hcnt_d = '0;
          end else if (int_1ms_en) begin
            if (hcnt_q == LONG_LAST) begin
              st_d  = LONG;
              lng_d = 1'b1;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
        end
        LONG: begin
          if (rel_ev) begin
            st_d   = IDLE;
            hcnt_d = '0;
          end
        end
        STRETCH: begin
          if (int_1ms_en) begin
            if (hcnt_q == OUT_LAST) begin
              st_d   = IDLE;
              hcnt_d = '0;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
        end
        default: begin
          st_d   = IDLE;
          hcnt_d = '0;
        end
      endcase

      if (!chan_en[c]) begin
        lvl_d  = 1'b1;
        dcnt_d = '0;
        st_d   = IDLE;
        hcnt_d = '0;
        lng_d  = 1'b0;
      end

      kout_d = ~chan_en[c] | (st_q != STRETCH);
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync1_q <= 1'b1;
        ks_q    <= 1'b1;
        lvl_q   <= 1'b1;
        dcnt_q  <= '0;
        st_q    <= IDLE;
        hcnt_q  <= '0;
        prs_q   <= 1'b0;
        rel_q   <= 1'b0;
        lng_q   <= 1'b0;
        kout_q  <= 1'b1;
      end else begin
        sync1_q <= key[c];
        ks_q    <= sync1_q;
        lvl_q   <= lvl_d;
        dcnt_q  <= dcnt_d;
        st_q    <= st_d;
        hcnt_q  <= hcnt_d;
        prs_q   <= press_ev;
        rel_q   <= rel_ev;
        lng_q   <= lng_d;
        kout_q  <= kout_d;
      end
    end

    assign key_level[c]         = lvl_q;
    assign press_pulse[c]       = prs_q;
    assign release_pulse[c]     = rel_q;
    assign long_pulse[c]        = lng_q;
    assign key_out[c]           = kout_q;
    assign fsm_state_o[2*c +: 2] = st_q;
  end

endmodule

// File: tb/tb_debounce_button_multi.sv
// Directed bench for debounce_button_multi: CH=2, DEB_MS=3, OUT_MS=5, LONG_MS=10, tick every 4 clocks.
module tb_debounce_button_multi;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_STRETCH = 2'd3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       int_1ms_en = 1'b0;
  logic [1:0] chan_en = 2'b11;
  logic [1:0] key = 2'b11;
  logic [1:0] key_level, press_pulse, release_pulse, long_pulse, key_out;
  logic [3:0] fsm_state;

  int checks = 0;
  int errors = 0;
  int tick_seen = 0;
  int ph = 0;
  int prs_n[2], rel_n[2], lng_n[2], str_n[2];
  int prs_t[2], rel_t[2], lng_t[2], kfall_t[2], krise_t[2];
  logic [1:0] kout_prev = 2'b11;

  debounce_button_multi #(
    .CH(2), .DEB_MS(3), .OUT_MS(5), .LONG_MS(10), .CW(13)
  ) dut (
    .clock(clock), .reset(reset), .int_1ms_en(int_1ms_en), .chan_en(chan_en), .key(key),
    .key_level(key_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .key_out(key_out), .fsm_state_o(fsm_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Tick generator and event recorder; tick_seen counts ticks the DUT has sampled.
  initial begin
    for (int c = 0; c < 2; c++) begin
      prs_n[c] = 0; rel_n[c] = 0; lng_n[c] = 0; str_n[c] = 0;
      prs_t[c] = 0; rel_t[c] = 0; lng_t[c] = 0; kfall_t[c] = 0; krise_t[c] = 0;
    end
    forever begin
      @(negedge clock);
      if (int_1ms_en) tick_seen++;
      for (int c = 0; c < 2; c++) begin
        if (press_pulse[c] === 1'b1) begin prs_n[c]++; prs_t[c] = tick_seen; end
        if (release_pulse[c] === 1'b1) begin rel_n[c]++; rel_t[c] = tick_seen; end
        if (long_pulse[c] === 1'b1) begin lng_n[c]++; lng_t[c] = tick_seen; end
        if (kout_prev[c] && key_out[c] === 1'b0) begin str_n[c]++; kfall_t[c] = tick_seen; end
        if (!kout_prev[c] && key_out[c] === 1'b1) krise_t[c] = tick_seen;
      end
      kout_prev = key_out;
      ph = (ph + 1) % 4;
      int_1ms_en = (ph == 0);
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_ticks(input int n);
    int target;
    int guard;
    target = tick_seen + n;
    guard = 0;
    while (tick_seen < target && guard < 1000) begin
      step();
      guard++;
    end
    if (tick_seen < target) begin
      checks++; errors++;
      $display("FAIL wait_ticks timeout got %0d want %0d", tick_seen, target);
    end
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (key_level !== 2'b11) begin errors++; $display("FAIL reset_key_level got %b want 11", key_level); end
    checks++; if (key_out !== 2'b11) begin errors++; $display("FAIL reset_key_out got %b want 11", key_out); end
    checks++; if ((press_pulse | release_pulse | long_pulse) !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", press_pulse | release_pulse | long_pulse); end
    checks++; if (fsm_state !== 4'h0) begin errors++; $display("FAIL reset_state got %h want 0", fsm_state); end
    reset = 1'b0;
    step(); step();
  endtask

  task automatic test_clean_press();
    int t, p0, r0, s0, p1, s1;
    p0 = prs_n[0]; r0 = rel_n[0]; s0 = str_n[0]; p1 = prs_n[1]; s1 = str_n[1];
    wait_ticks(1); t = tick_seen; key[0] = 1'b0;
    wait_ticks(2);
    checks++; if (key_level[0] !== 1'b1) begin errors++; $display("FAIL clean_level_early got %b want 1", key_level[0]); end
    wait_ticks(1);
    checks++; if (key_level[0] !== 1'b0) begin errors++; $display("FAIL clean_level_fall got %b want 0", key_level[0]); end
    checks++; if (prs_n[0] != p0 + 1) begin errors++; $display("FAIL clean_press_count got %0d want %0d", prs_n[0], p0 + 1); end
    checks++; if (prs_t[0] != t + 3) begin errors++; $display("FAIL clean_press_tick got %0d want %0d", prs_t[0], t + 3); end
    checks++; if (fsm_state[1:0] !== S_PRESSED) begin errors++; $display("FAIL clean_state_pressed got %0d want %0d", fsm_state[1:0], S_PRESSED); end
    wait_ticks(5); key[0] = 1'b1;
    wait_ticks(3);
    checks++; if (rel_n[0] != r0 + 1 || rel_t[0] != t + 11) begin errors++; $display("FAIL clean_release got n=%0d t=%0d want n=%0d t=%0d", rel_n[0], rel_t[0], r0 + 1, t + 11); end
    checks++; if (key_out[0] !== 1'b0) begin errors++; $display("FAIL clean_key_out_low got %b want 0", key_out[0]); end
    wait_ticks(6);
    checks++; if (key_out[0] !== 1'b1) begin errors++; $display("FAIL clean_key_out_high got %b want 1", key_out[0]); end
    checks++; if (str_n[0] != s0 + 1) begin errors++; $display("FAIL clean_stretch_count got %0d want %0d", str_n[0], s0 + 1); end
    checks++; if (krise_t[0] - kfall_t[0] != 5) begin errors++; $display("FAIL clean_stretch_len got %0d want 5", krise_t[0] - kfall_t[0]); end
    checks++; if (fsm_state[1:0] !== S_IDLE) begin errors++; $display("FAIL clean_state_idle got %0d want 0", fsm_state[1:0]); end
    checks++; if (prs_n[1] != p1 || str_n[1] != s1 || key_level[1] !== 1'b1) begin errors++; $display("FAIL clean_ch1_quiet got p=%0d s=%0d l=%b want p=%0d s=%0d l=1", prs_n[1], str_n[1], key_level[1], p1, s1); end
  endtask

  task automatic test_bounce();
    int t, p0;
    logic [1:0] pat_lvl [6];
    int pat_len [6];
    pat_lvl = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    pat_len = '{2, 1, 2, 2, 1, 2};
    p0 = prs_n[0];
    wait_ticks(1);
    for (int i = 0; i < 6; i++) begin
      key[0] = pat_lvl[i][0];
      wait_ticks(pat_len[i]);
    end
    checks++; if (prs_n[0] != p0 || key_level[0] !== 1'b1) begin errors++; $display("FAIL bounce_no_change got n=%0d l=%b want n=%0d l=1", prs_n[0], key_level[0], p0); end
    t = tick_seen; key[0] = 1'b0;
    wait_ticks(3);
    checks++; if (prs_n[0] != p0 + 1) begin errors++; $display("FAIL bounce_press_count got %0d want %0d", prs_n[0], p0 + 1); end
    checks++; if (prs_t[0] != t + 3) begin errors++; $display("FAIL bounce_press_tick got %0d want %0d", prs_t[0], t + 3); end
    key[0] = 1'b1;
    wait_ticks(12);
    checks++; if (fsm_state[1:0] !== S_IDLE || key_out[0] !== 1'b1) begin errors++; $display("FAIL bounce_settle got st=%0d ko=%b want st=0 ko=1", fsm_state[1:0], key_out[0]); end
  endtask

  task automatic test_long_press();
    int t, l0, s0;
    l0 = lng_n[0]; s0 = str_n[0];
    wait_ticks(1); t = tick_seen; key[0] = 1'b0;
    wait_ticks(15); key[0] = 1'b1;
    wait_ticks(3);
    checks++; if (lng_n[0] != l0 + 1) begin errors++; $display("FAIL long_count got %0d want %0d", lng_n[0], l0 + 1); end
    checks++; if (lng_t[0] - prs_t[0] != 10) begin errors++; $display("FAIL long_delay got %0d want 10", lng_t[0] - prs_t[0]); end
    checks++; if (rel_t[0] != t + 18) begin errors++; $display("FAIL long_release_tick got %0d want %0d", rel_t[0], t + 18); end
    checks++; if (fsm_state[1:0] !== S_IDLE) begin errors++; $display("FAIL long_state_idle got %0d want 0", fsm_state[1:0]); end
    wait_ticks(7);
    checks++; if (str_n[0] != s0 || key_out[0] !== 1'b1) begin errors++; $display("FAIL long_no_stretch got n=%0d ko=%b want n=%0d ko=1", str_n[0], key_out[0], s0); end
  endtask

  task automatic test_restretch_and_tie();
    int t, p0, r0, s0, l0;
    p0 = prs_n[0]; r0 = rel_n[0]; s0 = str_n[0];
    wait_ticks(1); t = tick_seen; key[0] = 1'b0;
    wait_ticks(4); key[0] = 1'b1;
    wait_ticks(3); key[0] = 1'b0;
    wait_ticks(3);
    checks++; if (prs_n[0] != p0 + 2 || prs_t[0] != t + 10) begin errors++; $display("FAIL repress_pulse got n=%0d t=%0d want n=%0d t=%0d", prs_n[0], prs_t[0], p0 + 2, t + 10); end
    checks++; if (key_out[0] !== 1'b0 || fsm_state[1:0] !== S_STRETCH) begin errors++; $display("FAIL repress_in_stretch got ko=%b st=%0d want ko=0 st=3", key_out[0], fsm_state[1:0]); end
    wait_ticks(3);
    checks++; if (key_out[0] !== 1'b1 || fsm_state[1:0] !== S_IDLE) begin errors++; $display("FAIL repress_end got ko=%b st=%0d want ko=1 st=0", key_out[0], fsm_state[1:0]); end
    checks++; if (krise_t[0] - kfall_t[0] != 5) begin errors++; $display("FAIL repress_stretch_len got %0d want 5", krise_t[0] - kfall_t[0]); end
    key[0] = 1'b1;
    wait_ticks(9);
    checks++; if (str_n[0] != s0 + 1 || rel_n[0] != r0 + 2 || fsm_state[1:0] !== S_IDLE) begin errors++; $display("FAIL repress_single_stretch got s=%0d r=%0d st=%0d want s=%0d r=%0d st=0", str_n[0], rel_n[0], fsm_state[1:0], s0 + 1, r0 + 2); end

    l0 = lng_n[0];
    wait_ticks(1); t = tick_seen; key[0] = 1'b0;
    wait_ticks(10); key[0] = 1'b1;
    wait_ticks(3);
    checks++; if (rel_t[0] != t + 13) begin errors++; $display("FAIL tie_release_tick got %0d want %0d", rel_t[0], t + 13); end
    checks++; if (lng_n[0] != l0) begin errors++; $display("FAIL tie_no_long got %0d want %0d", lng_n[0], l0); end
    checks++; if (fsm_state[1:0] !== S_STRETCH || key_out[0] !== 1'b0) begin errors++; $display("FAIL tie_stretch got st=%0d ko=%b want st=3 ko=0", fsm_state[1:0], key_out[0]); end
    wait_ticks(6);
  endtask

  task automatic test_chan_en();
    int t, e, p0, r0;
    p0 = prs_n[0]; r0 = rel_n[0];
    wait_ticks(1); t = tick_seen; key[0] = 1'b0;
    wait_ticks(5);
    checks++; if (fsm_state[1:0] !== S_PRESSED || key_level[0] !== 1'b0) begin errors++; $display("FAIL en_pressed got st=%0d l=%b want st=1 l=0", fsm_state[1:0], key_level[0]); end
    chan_en[0] = 1'b0;
    step();
    checks++; if (key_level[0] !== 1'b1 || key_out[0] !== 1'b1 || fsm_state[1:0] !== S_IDLE) begin errors++; $display("FAIL en_forced_idle got l=%b ko=%b st=%0d want l=1 ko=1 st=0", key_level[0], key_out[0], fsm_state[1:0]); end
    wait_ticks(2);
    checks++; if (rel_n[0] != r0 || prs_n[0] != p0 + 1) begin errors++; $display("FAIL en_no_pulses got r=%0d p=%0d want r=%0d p=%0d", rel_n[0], prs_n[0], r0, p0 + 1); end
    e = tick_seen; chan_en[0] = 1'b1;
    wait_ticks(3);
    checks++; if (prs_n[0] != p0 + 2 || prs_t[0] != e + 3) begin errors++; $display("FAIL en_fresh_press got n=%0d t=%0d want n=%0d t=%0d", prs_n[0], prs_t[0], p0 + 2, e + 3); end
    key[0] = 1'b1;
    wait_ticks(12);
    checks++; if (fsm_state[1:0] !== S_IDLE || key_out[0] !== 1'b1) begin errors++; $display("FAIL en_settle got st=%0d ko=%b want st=0 ko=1", fsm_state[1:0], key_out[0]); end
  endtask

  task automatic test_reset_mid_stretch();
    int s0, s1;
    wait_ticks(1); key = 2'b00;
    wait_ticks(4); key = 2'b11;
    wait_ticks(4);
    checks++; if (key_out !== 2'b00 || fsm_state !== 4'hF) begin errors++; $display("FAIL rst_pre_stretch got ko=%b st=%h want ko=00 st=f", key_out, fsm_state); end
    #1 reset = 1'b1;
    #1;
    checks++; if (key_out !== 2'b11) begin errors++; $display("FAIL rst_async_key_out got %b want 11", key_out); end
    checks++; if (key_level !== 2'b11 || (press_pulse | release_pulse | long_pulse) !== 2'b00) begin errors++; $display("FAIL rst_async_level got l=%b p=%b want l=11 p=00", key_level, press_pulse | release_pulse | long_pulse); end
    checks++; if (fsm_state !== 4'h0) begin errors++; $display("FAIL rst_async_state got %h want 0", fsm_state); end
    step(); step();
    reset = 1'b0;
    step();
    s0 = str_n[0]; s1 = str_n[1];
    wait_ticks(1); key = 2'b00;
    wait_ticks(4); key = 2'b11;
    wait_ticks(4);
    checks++; if (key_out !== 2'b00) begin errors++; $display("FAIL rst_resume_low got %b want 00", key_out); end
    wait_ticks(6);
    checks++; if (key_out !== 2'b11 || str_n[0] != s0 + 1 || str_n[1] != s1 + 1) begin errors++; $display("FAIL rst_resume_done got ko=%b s0=%0d s1=%0d want ko=11 s0=%0d s1=%0d", key_out, str_n[0], str_n[1], s0 + 1, s1 + 1); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_restretch_and_tie();
    test_chan_en();
    test_reset_mid_stretch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
